// File: rtl/audio_pkg.sv
// Shared widths, state encoding and duty scaling for the audio PWM player.
package audio_pkg;

    localparam int PWM_BITS        = 8;
    localparam int INDEX_W         = 8;
    localparam int PHASE_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Volume attenuation is a plain logical right shift of the table sample.
    function automatic logic [PWM_BITS-1:0] scale_duty(input logic [PWM_BITS-1:0] sample,
                                                        input logic [1:0]          volume);
        return sample >> volume;
    endfunction

endpackage

// File: rtl/audio_pwm_player_pwm_core.sv
// PWM timebase for audio_pwm_player: prescaler, 8-bit period counter,
// registered duty comparator and end-of-period wrap pulse.
module pwm_core
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out,
    output logic                wrap
);

    localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]    prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;

    assign tick = run && (prescaler == PRE_LAST);
    assign wrap = tick && (pwm_cnt == '1);

    // Everything is held at zero while not running so each play starts on a clean period.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            pwm_out   <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/audio_pwm_player.sv
// Audio PWM player: phase accumulator addresses an external waveform table and
// the captured sample sets the PWM duty. Define AUDIO_VOLUME_EN to add a volume port.
module audio_pwm_player
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int PHASE_W = PHASE_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PHASE_W-1:0]  tune_word,
`ifdef AUDIO_VOLUME_EN
    input  logic [1:0]          volume,
`endif
    output logic [INDEX_W-1:0]  index,
    input  logic [PWM_BITS-1:0] sample_in,
    output logic                pwm_out,
    output logic                amp_en,
    output logic                sample_strobe
);

    state_t              state;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  phase_adv;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] next_duty;
    logic                run;
    logic                wrap;

`ifdef AUDIO_VOLUME_EN
    assign next_duty = scale_duty(sample_in, volume);
`else
    assign next_duty = sample_in;
`endif

    assign phase_adv = phase + tune_word;
    assign run       = (state == PLAY) || (state == DRAIN);

    pwm_core #(
        .CLK_DIV (CLK_DIV)
    ) u_pwm_core (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .duty    (duty),
        .pwm_out (pwm_out),
        .wrap    (wrap)
    );

    // index always mirrors the phase just written, so the table has a whole
    // period to settle before its output is captured at the next wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            phase         <= '0;
            index         <= '0;
            duty          <= '0;
            amp_en        <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    phase  <= '0;
                    index  <= '0;
                    duty   <= '0;
                    amp_en <= enable;
                    if (enable) begin
                        state <= START;
                    end
                end
                START: begin
                    duty          <= next_duty;
                    phase         <= tune_word;
                    index         <= tune_word[PHASE_W-1 -: INDEX_W];
                    sample_strobe <= 1'b1;
                    amp_en        <= 1'b1;
                    state         <= PLAY;
                end
                PLAY: begin
                    if (wrap) begin
                        duty          <= next_duty;
                        phase         <= phase_adv;
                        index         <= phase_adv[PHASE_W-1 -: INDEX_W];
                        sample_strobe <= 1'b1;
                    end
                    if (!enable) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wrap) begin
                        amp_en <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_pwm_player.sv
// Scoreboard bench for audio_pwm_player: identity-table instance (CLK_DIV=1)
// and constant-sample instance (CLK_DIV=4) for the duty/volume check.
module tb_audio_pwm_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1, en2;
    logic [15:0] tune1, tune2;
    logic [7:0]  idx1, idx2, smp1, smp2;
    logic        pwm1, pwm2, amp1, amp2, stb1, stb2;
`ifdef AUDIO_VOLUME_EN
    logic [1:0]  vol1 = 2'd0;
    logic [1:0]  vol2 = 2'd2;
    localparam int VOL_HIGH = 200;
`else
    localparam int VOL_HIGH = 800;
`endif

    int tests = 0;
    int fails = 0;

    initial forever #5 clk = ~clk;

    assign smp1 = idx1;
    assign smp2 = 8'hC8;

    audio_pwm_player #(.CLK_DIV(1), .PHASE_W(16)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .tune_word(tune1),
`ifdef AUDIO_VOLUME_EN
        .volume(vol1),
`endif
        .index(idx1), .sample_in(smp1), .pwm_out(pwm1), .amp_en(amp1), .sample_strobe(stb1)
    );

    audio_pwm_player #(.CLK_DIV(4), .PHASE_W(16)) dut2 (
        .clk(clk), .rst(rst), .enable(en2), .tune_word(tune2),
`ifdef AUDIO_VOLUME_EN
        .volume(vol2),
`endif
        .index(idx2), .sample_in(smp2), .pwm_out(pwm2), .amp_en(amp2), .sample_strobe(stb2)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: index after strobe j and duty played in period k.
    function automatic int model_idx(input logic [15:0] tune, input int j);
        logic [31:0] p;
        p = 32'(j + 1) * 32'(tune);
        return int'(p[15:8]);
    endfunction

    function automatic int model_duty(input logic [15:0] tune, input int k);
        logic [31:0] p;
        p = 32'(k) * 32'(tune);
        return int'(p[15:8]);
    endfunction

    typedef struct {
        int idx;
        int high;
        bit first;
    } exp_t;

    exp_t sb[$];
    int   end_q[$];
    int   exp2[$];

    task automatic push_session(input logic [15:0] tune, input int m);
        exp_t e;
        for (int j = 0; j <= m; j++) begin
            e.idx   = model_idx(tune, j);
            e.first = (j == 0);
            e.high  = (j == 0) ? 0 : model_duty(tune, j - 1);
            sb.push_back(e);
        end
        end_q.push_back(model_duty(tune, m));
    endtask

    // Monitor for dut1
    bit mon_on = 1'b1;
    int high_cnt = 0;
    int gap = 0;
    bit prev_amp1 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            gap++;
            if (pwm1 === 1'b1) high_cnt++;
            if (stb1 === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_index", int'(idx1), e.idx);
                    if (!e.first) begin
                        check("period_high_clocks", high_cnt, e.high);
                        check("strobe_spacing", gap, 256);
                    end
                end
                high_cnt = 0;
                gap = 0;
            end else if (prev_amp1 && amp1 === 1'b0) begin
                if (end_q.size() == 0) check("unexpected_stop", 1, 0);
                else check("last_period_high_clocks", high_cnt, end_q.pop_front());
                high_cnt = 0;
            end
        end
        prev_amp1 = (amp1 === 1'b1);
    end

    // Monitor for dut2
    int high2 = 0;
    int gap2 = 0;
    bit seen2 = 1'b0;
    bit prev_amp2 = 1'b0;

    always @(negedge clk) begin
        gap2++;
        if (pwm2 === 1'b1) high2++;
        if (stb2 === 1'b1) begin
            if (seen2) begin
                if (exp2.size() == 0) check("vol_unexpected_strobe", 1, 0);
                else check("vol_period_high_clocks", high2, exp2.pop_front());
                check("vol_strobe_spacing", gap2, 1024);
            end
            seen2 = 1'b1;
            high2 = 0;
            gap2 = 0;
        end else if (prev_amp2 && amp2 === 1'b0) begin
            if (exp2.size() == 0) check("vol_unexpected_stop", 1, 0);
            else check("vol_last_period_high_clocks", high2, exp2.pop_front());
            seen2 = 1'b0;
            high2 = 0;
        end
        prev_amp2 = (amp2 === 1'b1);
    end

    task automatic wait_idle1();
        int n;
        n = 0;
        while (amp1 !== 1'b0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("drain_finished_in_time", int'(amp1 === 1'b0), 1);
        repeat (2) @(negedge clk);
        check("idle_amp_en", int'(amp1), 0);
        check("idle_pwm_out", int'(pwm1), 0);
        check("idle_index", int'(idx1), 0);
    endtask

    // One play session starting at the current negedge with enable already
    // high; enable is dropped when pwm_cnt reaches 100 in period m.
    task automatic play_and_stop(input int m, input int already);
        repeat (256 * m + 102 - already) @(negedge clk);
        en1 = 1'b0;
    endtask

    initial begin
        exp_t e;
        int n;
        rst = 1'b1; en1 = 1'b0; en2 = 1'b0; tune1 = 16'h0100; tune2 = 16'h0100;
        repeat (2) @(negedge clk);

        // Reset held while enable is asserted: no start
        en1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_pwm_out", int'(pwm1), 0);
            check("rst_amp_en", int'(amp1), 0);
            check("rst_index", int'(idx1), 0);
            check("rst_strobe", int'(stb1), 0);
        end

        // Ramp playback
        push_session(16'h0100, 4);
        rst = 1'b0;
        @(negedge clk);
        check("amp_en_after_enable", int'(amp1), 1);
        check("no_strobe_before_start", int'(stb1), 0);
        play_and_stop(4, 1);
        wait_idle1();

        // Fractional step
        tune1 = 16'h0080;
        push_session(16'h0080, 4);
        en1 = 1'b1;
        play_and_stop(4, 0);
        wait_idle1();

        // Phase wrap-around
        tune1 = 16'hFF00;
        push_session(16'hFF00, 3);
        en1 = 1'b1;
        play_and_stop(3, 0);
        wait_idle1();

        // Stop, then re-enable during drain: full period, IDLE, then fresh START
        tune1 = 16'h0100;
        push_session(16'h0100, 1);
        push_session(16'h0100, 1);
        en1 = 1'b1;
        play_and_stop(1, 0);
        repeat (50) @(negedge clk);
        check("drain_keeps_amp_en", int'(amp1), 1);
        en1 = 1'b1;
        repeat (106) @(negedge clk);
        play_and_stop(1, 0);
        wait_idle1();

        // Reset in the middle of period 1
        e.idx = 1; e.first = 1'b1; e.high = 0;
        sb.push_back(e);
        e.idx = 2; e.first = 1'b0; e.high = 0;
        sb.push_back(e);
        en1 = 1'b1;
        repeat (256 + 102) @(negedge clk);
        mon_on = 1'b0;
        check("scoreboard_drained_before_rst", sb.size(), 0);
        en1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pwm_out", int'(pwm1), 0);
        check("midrst_amp_en", int'(amp1), 0);
        check("midrst_index", int'(idx1), 0);
        check("midrst_strobe", int'(stb1), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_stays_idle", int'(amp1), 0);
        high_cnt = 0;
        gap = 0;
        mon_on = 1'b1;

        // Duty from a constant sample at CLK_DIV=4 (volume shift when enabled)
        exp2.push_back(VOL_HIGH);
        exp2.push_back(VOL_HIGH);
        en2 = 1'b1;
        repeat (1500) @(negedge clk);
        en2 = 1'b0;
        n = 0;
        while (amp2 !== 1'b0 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("vol_drain_finished_in_time", int'(amp2 === 1'b0), 1);
        repeat (2) @(negedge clk);
        check("vol_scoreboard_empty", exp2.size(), 0);
        check("scoreboard_empty", sb.size(), 0);
        check("end_queue_empty", end_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
